comparator: RTL and testbench

COMPARATOR -- requirements
Module: comparator

---
 rtl/comparator_if.sv | 29 ++
 rtl/comparator.sv | 113 +++++++++++
 tb/tb_comparator.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/comparator_if.sv
// Bundle of the comparator's sample inputs and registered result/statistics outputs.
// The master side issues samples; the slave side is the comparator itself.
interface comparator_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             clear;
    logic             in_valid;
    logic             is_signed;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             smaller;
    logic             greater;
    logic             equal;
    logic [N-1:0]     max_val;
    logic [N-1:0]     min_val;
    logic [CNT_W-1:0] eq_count;

    modport master (
        output clear, in_valid, is_signed, a, b,
        input  out_valid, smaller, greater, equal, max_val, min_val, eq_count
    );

    modport slave (
        input  clear, in_valid, is_signed, a, b,
        output out_valid, smaller, greater, equal, max_val, min_val, eq_count
    );
endinterface

// File: rtl/comparator.sv
// Registered signed/unsigned magnitude comparator with running max/min of all
// accepted operands and a saturating count of equal samples.
module comparator #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    comparator_if.slave bus
);
    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    localparam logic [N-1:0]     SIGN_FLIP = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             out_valid_q, out_valid_d;
    logic             smaller_q, smaller_d;
    logic             greater_q, greater_d;
    logic             equal_q, equal_d;
    logic [N-1:0]     max_q, max_d;
    logic [N-1:0]     min_q, min_d;
    logic [CNT_W-1:0] eq_count_q, eq_count_d;
    // Set once the extrema hold at least one sample since reset/clear.
    logic             have_q, have_d;

    logic [N-1:0] flip;
    logic [N-1:0] a_key, b_key, max_key, min_key;
    logic [N-1:0] samp_max, samp_min;
    logic         a_lt_b, a_eq_b;

    // Order keys for the sample and the stored extrema under this sample's mode.
    always_comb begin
        flip     = bus.is_signed ? SIGN_FLIP : '0;
        a_key    = bus.a ^ flip;
        b_key    = bus.b ^ flip;
        max_key  = max_q ^ flip;
        min_key  = min_q ^ flip;
        a_lt_b   = a_key < b_key;
        a_eq_b   = bus.a == bus.b;
        samp_max = a_lt_b ? bus.b : bus.a;
        samp_min = a_lt_b ? bus.a : bus.b;
    end

    // Next-state for result flags and running statistics; clear beats the old
    // statistics but a same-cycle sample still becomes the first one after it.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
        out_valid_d = bus.in_valid;
        smaller_d   = smaller_q;
        greater_d   = greater_q;
        equal_d     = equal_q;
        max_d       = max_q;
        min_d       = min_q;
        eq_count_d  = eq_count_q;
        have_d      = have_q;

        if (bus.clear) begin
            max_d      = '0;
            min_d      = '0;
            eq_count_d = '0;
            have_d     = 1'b0;
        end

        if (bus.in_valid) begin
            smaller_d = a_lt_b;
            equal_d   = a_eq_b;
            greater_d = !a_lt_b && !a_eq_b;

            if (bus.clear || !have_q) begin
                max_d = samp_max;
                min_d = samp_min;
            end else begin
                if ((samp_max ^ flip) > max_key) max_d = samp_max;
                if ((samp_min ^ flip) < min_key) min_d = samp_min;
            end
            have_d = 1'b1;

            if (a_eq_b && eq_count_d != CNT_MAX) eq_count_d = eq_count_d + CNT_W'(1);
        end
    end

    // State registers; reset clears everything asynchronously, dropping any pending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            smaller_q   <= 1'b0;
            greater_q   <= 1'b0;
            equal_q     <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            eq_count_q  <= '0;
            have_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            smaller_q   <= smaller_d;
            greater_q   <= greater_d;
            equal_q     <= equal_d;
            max_q       <= max_d;
            min_q       <= min_d;
            eq_count_q  <= eq_count_d;
            have_q      <= have_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.smaller   = smaller_q;
    assign bus.greater   = greater_q;
    assign bus.equal     = equal_q;
    assign bus.max_val   = max_q;
    assign bus.min_val   = min_q;
    assign bus.eq_count  = eq_count_q;
endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for the comparator: the driver models each sample with
// integer arithmetic and queues the expected result; a monitor one time unit
// after every rising edge pops and compares, or checks the idle/hold state.
module tb_comparator;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        bit               s, g, e;
        logic [N-1:0]     mx, mn;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparator_if #(.N(N), .CNT_W(CNT_W)) bus ();
    comparator #(.N(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    // Reference state: what the DUT should show after the most recent edge.
    bit               m_s, m_g, m_e, m_have;
    logic [N-1:0]     m_mx, m_mn;
    int               m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Numeric value of an operand under the chosen interpretation.
    function automatic int val(input logic [N-1:0] x, input bit sgn);
        int u;
        u = int'(x);
        if (sgn && u >= (1 << (N - 1))) u = u - (1 << N);
        return u;
    endfunction

    task automatic model_reset();
        m_s = 0; m_g = 0; m_e = 0; m_have = 0;
        m_mx = '0; m_mn = '0; m_cnt = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs and advance the reference model to match.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit sgn, input bit clr, input bit vld);
        int va, vb;
        logic [N-1:0] hi, lo;
        exp_t e;
        bus.a = a; bus.b = b; bus.is_signed = sgn; bus.clear = clr; bus.in_valid = vld;
        if (clr) begin
            m_have = 0; m_mx = '0; m_mn = '0; m_cnt = 0;
        end
        if (vld) begin
            va = val(a, sgn);
            vb = val(b, sgn);
            m_s = va < vb; m_g = va > vb; m_e = va == vb;
            hi = (va >= vb) ? a : b;
            lo = (va >= vb) ? b : a;
            if (!m_have) begin
                m_mx = hi; m_mn = lo;
            end else begin
                if (val(hi, sgn) > val(m_mx, sgn)) m_mx = hi;
                if (val(lo, sgn) < val(m_mn, sgn)) m_mn = lo;
            end
            m_have = 1;
            if (a == b && m_cnt < CMAX) m_cnt++;
            e.s = m_s; e.g = m_g; e.e = m_e; e.mx = m_mx; e.mn = m_mn;
            e.cnt = CNT_W'(m_cnt);
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit sgn, input bit clr, input bit vld);
        @(negedge clk);
        drive(a, b, sgn, clr, vld);
    endtask

    task automatic idle();
        issue('0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: a queued result must appear exactly one edge after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe", 32'(bus.out_valid), 32'd1);
                check("smaller", 32'(bus.smaller), 32'(e.s));
                check("greater", 32'(bus.greater), 32'(e.g));
                check("equal", 32'(bus.equal), 32'(e.e));
                check("max_val", 32'(bus.max_val), 32'(e.mx));
                check("min_val", 32'(bus.min_val), 32'(e.mn));
                check("eq_count", 32'(bus.eq_count), 32'(e.cnt));
            end else begin
                check("idle_strobe", 32'(bus.out_valid), 32'd0);
                check("hold_smaller", 32'(bus.smaller), 32'(m_s));
                check("hold_greater", 32'(bus.greater), 32'(m_g));
                check("hold_equal", 32'(bus.equal), 32'(m_e));
                check("idle_max", 32'(bus.max_val), 32'(m_mx));
                check("idle_min", 32'(bus.min_val), 32'(m_mn));
                check("idle_cnt", 32'(bus.eq_count), 32'(m_cnt));
            end
        end
    end

    initial begin
        logic [N-1:0] ra, rb;
        bit rs, rc, rv;
        model_reset();
        bus.a = '0; bus.b = '0; bus.is_signed = 0; bus.clear = 0; bus.in_valid = 0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", {29'd0, bus.smaller, bus.greater, bus.equal}, 32'd0);
        check("rst_max", 32'(bus.max_val), 32'd0);
        check("rst_min", 32'(bus.min_val), 32'd0);
        check("rst_cnt", 32'(bus.eq_count), 32'd0);

        // A sample presented as reset releases is accepted on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        issue(4'd3, 4'd15, 1'b0, 1'b0, 1'b1);
        issue(4'd12, 4'd9, 1'b0, 1'b0, 1'b1);
        issue(4'd13, 4'd13, 1'b0, 1'b0, 1'b1);
        idle();
        check("seq_max", 32'(bus.max_val), 32'd15);
        check("seq_min", 32'(bus.min_val), 32'd0);
        check("seq_cnt", 32'(bus.eq_count), 32'd2);

        // Signed versus unsigned ordering of the same operands.
        issue(4'd12, 4'd3, 1'b1, 1'b0, 1'b1);
        idle();
        check("signed_smaller", 32'(bus.smaller), 32'd1);
        issue(4'd12, 4'd3, 1'b0, 1'b0, 1'b1);
        idle();
        check("unsigned_greater", 32'(bus.greater), 32'd1);

        // Saturation: five equal samples after a clear.
        issue('0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) issue(4'(i), 4'(i), i[0], 1'b0, 1'b1);
        idle();
        check("sat_cnt", 32'(bus.eq_count), 32'd3);

        // Clear together with a sample: the sample seeds the statistics.
        issue(4'd7, 4'd2, 1'b0, 1'b1, 1'b1);
        idle();
        check("clr_max", 32'(bus.max_val), 32'd7);
        check("clr_min", 32'(bus.min_val), 32'd2);
        check("clr_cnt", 32'(bus.eq_count), 32'd0);
        check("clr_greater", 32'(bus.greater), 32'd1);

        // Asynchronous reset while a result is pending.
        issue(4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
        issue(4'd1, 4'd9, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_flags", {29'd0, bus.smaller, bus.greater, bus.equal}, 32'd0);
        check("arst_max", 32'(bus.max_val), 32'd0);
        check("arst_min", 32'(bus.min_val), 32'd0);
        check("arst_cnt", 32'(bus.eq_count), 32'd0);
        model_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive('0, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            rv = $urandom_range(0, 3) != 0;
            rc = $urandom_range(0, 19) == 0;
            if (rc && rv && ra == rb) rb = ra + 4'd1;
            issue(ra, rb, rs, rc, rv);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
